// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
// The read-return owner encoding is shared with anything that snoops the port.
package dmem_port_arbiter_pkg;

  // Who owns the read data coming back from memory this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one synchronous memory port between the
// MEM-stage load/store path and the board debug/display reader. The core wins
// by default; a debug reader starved for STARVE_MAX cycles gets one forced slot.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  // core (MEM stage) side
  input  logic                core_req,
  input  logic                core_we,
  input  logic [DATA_W/8-1:0] core_be,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_stall,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_rvalid,
  // debug reader side
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic                dbg_gnt,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                dbg_rvalid,
  // memory side
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              dbg_rvalid_q;

  logic force_dbg;
  logic gnt_core;
  logic gnt_dbg;

  // Grant decision: forced debug slot, then core, then opportunistic debug.
  always_comb begin
    force_dbg = dbg_req && (starve_cnt_q == CntMax);
    gnt_dbg   = dbg_req && (force_dbg || !core_req);
    gnt_core  = core_req && !gnt_dbg;
  end

  assign core_stall = core_req && !gnt_core;
  assign dbg_gnt    = gnt_dbg;

  // Memory port mux driven from the winner; quiet when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (gnt_dbg) begin
      mem_en   = 1'b1;
      mem_be   = {BE_W{1'b1}};
      mem_addr = dbg_addr;
    end else if (gnt_core) begin
      mem_en = 1'b1;
      mem_we = core_we;
      // Loads always fetch the whole word; byte selection happens downstream.
      mem_be = core_we ? core_be : {BE_W{1'b1}};
    end
  end

  // Next-state for starvation counter and read-return owner.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg_req || gnt_dbg) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < CntMax) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    rd_owner_d = OWN_NONE;
    if (gnt_dbg) begin
      rd_owner_d = OWN_DBG;
    end else if (gnt_core && !core_we) begin
      rd_owner_d = OWN_CORE;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read-return tracker: tags the returning word and latches debug reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q   <= OWN_NONE;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      dbg_rvalid_q <= (rd_owner_q == OWN_DBG);
      if (rd_owner_q == OWN_DBG) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Core load data passes straight through in the return cycle.
  assign core_rvalid = (rd_owner_q == OWN_CORE);
  assign core_rdata  = mem_rdata;
  assign dbg_rdata   = dbg_rdata_q;
  assign dbg_rvalid  = dbg_rvalid_q;

endmodule
